// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer: collects PS2 scancode bytes into a DEPTH-character ASCII line
// and hands the finished line to the processor side with a valid/ready handshake.
//
// Ports:
//   clock           system clock, rising edge
//   resetn          asynchronous active-low reset
//   ps2_key_data    scancode byte from PS2_Interface
//   ps2_key_pressed byte strobe (one event per rising level, any length)
//   line_data       live line, newest char in [7:0], unused positions zero
//   line_len        chars in line_data (0..DEPTH)
//   cmd_data        committed command, same packing as line_data
//   cmd_len         chars in cmd_data
//   cmd_valid       command available
//   cmd_ready       consumer accepts the command
//   overflow        sticky: a printable char was dropped on a full line
module ps2_line_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LEN_W = 3
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [7:0]           ps2_key_data,
    input  logic                 ps2_key_pressed,
    output logic [DEPTH*8-1:0]   line_data,
    output logic [LEN_W-1:0]     line_len,
    output logic [DEPTH*8-1:0]   cmd_data,
    output logic [LEN_W-1:0]     cmd_len,
    output logic                 cmd_valid,
    input  logic                 cmd_ready,
    output logic                 overflow
);

    localparam int unsigned LINE_W = DEPTH * 8;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] BREAK     = 2'd1;
    localparam logic [1:0] EXT       = 2'd2;
    localparam logic [1:0] EXT_BREAK = 2'd3;

    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BKSP  = 8'h66;
    localparam logic [7:0] CODE_ESC   = 8'h76;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    logic [1:0]        state, state_nxt;
    logic              pressed_d;
    logic              event_c;
    logic [7:0]        ascii_c;
    logic [LINE_W-1:0] line_data_nxt, cmd_data_nxt;
    logic [LEN_W-1:0]  line_len_nxt, cmd_len_nxt;
    logic              cmd_valid_nxt, overflow_nxt;

    // Scancode to ASCII for printable keys; zero means not printable.
    function automatic logic [7:0] to_ascii(input logic [7:0] code);
        logic [7:0] a;
        a = 8'h00;
        case (code)
            8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
            8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
            8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
            8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
            8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
            8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
            8'h45: a = 8'h30; 8'h16: a = 8'h31; 8'h1E: a = 8'h32; 8'h26: a = 8'h33;
            8'h25: a = 8'h34; 8'h2E: a = 8'h35; 8'h36: a = 8'h36; 8'h3D: a = 8'h37;
            8'h3E: a = 8'h38; 8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign event_c = ps2_key_pressed & ~pressed_d;
    assign ascii_c = to_ascii(ps2_key_data);

    // State register and all registered outputs.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            pressed_d <= 1'b0;
            line_data <= '0;
            line_len  <= '0;
            cmd_data  <= '0;
            cmd_len   <= '0;
            cmd_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            pressed_d <= ps2_key_pressed;
            line_data <= line_data_nxt;
            line_len  <= line_len_nxt;
            cmd_data  <= cmd_data_nxt;
            cmd_len   <= cmd_len_nxt;
            cmd_valid <= cmd_valid_nxt;
            overflow  <= overflow_nxt;
        end
    end

    // Prefix decoding, line editing and command handshake.
    always_comb begin
        state_nxt     = state;
        line_data_nxt = line_data;
        line_len_nxt  = line_len;
        cmd_data_nxt  = cmd_data;
        cmd_len_nxt   = cmd_len;
        cmd_valid_nxt = cmd_valid;
        overflow_nxt  = overflow;

        if (cmd_valid && cmd_ready) begin
            cmd_valid_nxt = 1'b0;
        end

        if (event_c) begin
            case (state)
                IDLE: begin
                    if (ps2_key_data == CODE_BREAK) begin
                        state_nxt = BREAK;
                    end else if (ps2_key_data == CODE_EXT) begin
                        state_nxt = EXT;
                    end else if (ascii_c != 8'h00) begin
                        if (line_len < DEPTH_L) begin
                            line_data_nxt = (line_data << 8) | LINE_W'(ascii_c);
                            line_len_nxt  = line_len + LEN_W'(1);
                        end else begin
                            overflow_nxt = 1'b1;
                        end
                    end else if (ps2_key_data == CODE_BKSP) begin
                        if (line_len != '0) begin
                            line_data_nxt = line_data >> 8;
                            line_len_nxt  = line_len - LEN_W'(1);
                        end
                    end else if (ps2_key_data == CODE_ESC) begin
                        line_data_nxt = '0;
                        line_len_nxt  = '0;
                    end else if (ps2_key_data == CODE_ENTER) begin
                        // A pending command blocks ENTER unless it leaves on this edge.
                        if ((line_len != '0) && (!cmd_valid || cmd_ready)) begin
                            cmd_data_nxt  = line_data;
                            cmd_len_nxt   = line_len;
                            cmd_valid_nxt = 1'b1;
                            line_data_nxt = '0;
                            line_len_nxt  = '0;
                            overflow_nxt  = 1'b0;
                        end
                    end
                end
                EXT: begin
                    state_nxt = (ps2_key_data == CODE_BREAK) ? EXT_BREAK : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
